// File: rtl/n64_vgen.sv
// rtl/n64_vgen.sv - synthetic N64 VI bus source (sync nibble + RGB), NTSC/PAL, 240p/480i
// Optional feature macro: N64_VGEN_COLORBARS_EN (8 vertical colour bars instead of flat grey).
module n64_vgen #(
    parameter logic [9:0] H_TOTAL_NTSC = 10'd773,
    parameter logic [9:0] H_TOTAL_PAL  = 10'd794,
    parameter logic [9:0] H_SYNC_W     = 10'd57,
    parameter logic [9:0] CLAMP_W      = 10'd30,
    parameter logic [9:0] H_ACT_START  = 10'd108,
    parameter logic [9:0] H_ACT_W      = 10'd640,
    parameter logic [8:0] V_SYNC_LINES = 9'd3,
    parameter logic [8:0] V_ACT_START  = 9'd18,
    parameter logic [8:0] V_ACT_NTSC   = 9'd240,
    parameter logic [8:0] V_ACT_PAL    = 9'd288,
    parameter logic [8:0] V_LINES_NTSC = 9'd263,
    parameter logic [8:0] V_LINES_PAL  = 9'd313
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       en_i,
    input  logic       palmode_i,
    input  logic       n64_480i_i,
    output logic       nVDSYNC_o,
    output logic [6:0] D_o,
    output logic [1:0] vmode_o
);
    logic [1:0] phase, phase_n;
    logic [9:0] h, h_n;
    logic [8:0] v, v_n;
    logic       field, field_n;
    logic [1:0] vmode, vmode_n;

    logic [9:0] h_total, h_half;
    logic [8:0] v_last, v_act;
    logic       n_hsync, n_vsync, n_clamp, active;
    logic [6:0] pix;
    logic       nvd_n;
    logic [6:0] d_n;

    always_comb begin
        h_total = vmode[1] ? H_TOTAL_PAL : H_TOTAL_NTSC;
        h_half  = h_total >> 1;
        v_act   = vmode[1] ? V_ACT_PAL : V_ACT_NTSC;
        // Field 1 of an interlaced frame is one line short; together with the
        // mid-line vsync this yields the half-line offset between fields.
        v_last  = (vmode[1] ? V_LINES_PAL : V_LINES_NTSC) - 9'd1
                  - {8'd0, vmode[0] & field};
        n_hsync = !(h < H_SYNC_W);
        n_clamp = !((h >= H_SYNC_W) && (h < H_SYNC_W + CLAMP_W));
        if (field)
            n_vsync = !((v < V_SYNC_LINES - 9'd1) ||
                        ((v == V_SYNC_LINES - 9'd1) && (h < h_half)));
        else
            n_vsync = !((v < V_SYNC_LINES) ||
                        (vmode[0] && (v == v_last) && (h >= h_half)));
        active  = (h >= H_ACT_START) && (h < H_ACT_START + H_ACT_W) &&
                  (v >= V_ACT_START) && (v < V_ACT_START + v_act);
    end

`ifdef N64_VGEN_COLORBARS_EN
    localparam logic [9:0] BAR_W = H_ACT_W >> 3;
    logic [9:0] bar_off;
    logic [2:0] bar_idx;

    always_comb begin
        bar_off = h - H_ACT_START;
        bar_idx = 3'(bar_off / BAR_W);
        case (phase)
            2'd1:    pix = bar_idx[2] ? 7'h7F : 7'h00;
            2'd2:    pix = bar_idx[1] ? 7'h7F : 7'h00;
            default: pix = bar_idx[0] ? 7'h7F : 7'h00;
        endcase
    end
`else
    assign pix = 7'h3F;
`endif

    always_comb begin
        phase_n = phase;
        h_n     = h;
        v_n     = v;
        field_n = field;
        vmode_n = vmode;
        if (en_i) begin
            phase_n = phase + 2'd1;
            if (phase == 2'd3) begin
                if (h == h_total - 10'd1) begin
                    h_n = '0;
                    if (v == v_last) begin
                        v_n = '0;
                        // The requested mode only takes effect at a field-0 start.
                        if (vmode[0] && !field) begin
                            field_n = 1'b1;
                        end else begin
                            field_n = 1'b0;
                            vmode_n = {palmode_i, n64_480i_i};
                        end
                    end else begin
                        v_n = v + 9'd1;
                    end
                end else begin
                    h_n = h + 10'd1;
                end
            end
        end
    end

    always_comb begin
        nvd_n = 1'b1;
        d_n   = 7'h00;
        if (en_i) begin
            if (phase == 2'd0) begin
                nvd_n = 1'b0;
                d_n   = {3'b000, n_vsync, n_clamp, n_hsync, n_vsync & n_hsync};
            end else if (active) begin
                d_n   = pix;
            end
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            phase     <= '0;
            h         <= '0;
            v         <= '0;
            field     <= 1'b0;
            vmode     <= {palmode_i, n64_480i_i};
            nVDSYNC_o <= 1'b1;
            D_o       <= 7'h00;
        end else begin
            phase     <= phase_n;
            h         <= h_n;
            v         <= v_n;
            field     <= field_n;
            vmode     <= vmode_n;
            nVDSYNC_o <= nvd_n;
            D_o       <= d_n;
        end
    end

    assign vmode_o = vmode;

endmodule

// File: tb/tb_n64_vgen.sv
// tb/tb_n64_vgen.sv - self-checking bench for n64_vgen (small-timing and default-timing instances)
module tb_n64_vgen;
    logic       VCLK = 1'b0;
    logic       RST = 1'b1;
    logic       en = 1'b1;
    logic       pal_i = 1'b0;
    logic       il_i = 1'b0;
    logic       nvd_s, nvd_d;
    logic [6:0] d_s, d_d;
    logic [1:0] md_s, md_d;

    int n_chk = 0;
    int n_bad = 0;

    always #5 VCLK = ~VCLK;

    n64_vgen #(
        .H_TOTAL_NTSC(10'd31), .H_TOTAL_PAL(10'd33), .H_SYNC_W(10'd4), .CLAMP_W(10'd3),
        .H_ACT_START(10'd10), .H_ACT_W(10'd16), .V_SYNC_LINES(9'd3), .V_ACT_START(9'd4),
        .V_ACT_NTSC(9'd6), .V_ACT_PAL(9'd8), .V_LINES_NTSC(9'd13), .V_LINES_PAL(9'd15)
    ) u_small (
        .VCLK(VCLK), .RST(RST), .en_i(en), .palmode_i(pal_i), .n64_480i_i(il_i),
        .nVDSYNC_o(nvd_s), .D_o(d_s), .vmode_o(md_s)
    );

    n64_vgen u_dflt (
        .VCLK(VCLK), .RST(RST), .en_i(en), .palmode_i(pal_i), .n64_480i_i(il_i),
        .nVDSYNC_o(nvd_d), .D_o(d_d), .vmode_o(md_d)
    );

    // Timing configuration per instance: index 0 = u_small, 1 = u_dflt.
    int c_htn [2] = '{31, 773};
    int c_htp [2] = '{33, 794};
    int c_hsw [2] = '{4, 57};
    int c_clw [2] = '{3, 30};
    int c_has [2] = '{10, 108};
    int c_haw [2] = '{16, 640};
    int c_vsl [2] = '{3, 3};
    int c_vas [2] = '{4, 18};
    int c_van [2] = '{6, 240};
    int c_vap [2] = '{8, 288};
    int c_vln [2] = '{13, 263};
    int c_vlp [2] = '{15, 313};

    // Reference model: position is a slot index t within one frame period
    // (one field for 240p, a field pair for 480i) plus the 4-cycle phase.
    int         m_ph [2];
    int         m_t  [2];
    logic [1:0] m_md [2];
    int         e_nvd [2];
    int         e_d   [2];
    logic [1:0] e_md  [2];

    int  mon_s = 0, mon_hc = 0;
    bit  mon_seen = 0, prev_vs = 1, prev_hs = 1;
    int  iv_q[$];
    int  hc_q[$];

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int period(int k, logic [1:0] md);
        int ht, l0;
        ht = md[1] ? c_htp[k] : c_htn[k];
        l0 = md[1] ? c_vlp[k] : c_vln[k];
        return md[0] ? (2 * l0 - 1) * ht : l0 * ht;
    endfunction

    function automatic int slot_data(int k, int ph, int t, logic [1:0] md);
        int ht, l0, hh, ln, vv, f1, vact, b;
        bit vs_lo, hs_lo, cl_lo, act;
        ht = md[1] ? c_htp[k] : c_htn[k];
        l0 = md[1] ? c_vlp[k] : c_vln[k];
        hh = t % ht;
        ln = t / ht;
        vv = (md[0] && ln >= l0) ? ln - l0 : ln;
        f1 = (l0 - 1) * ht + ht / 2;
        vs_lo = (t < c_vsl[k] * ht) || (md[0] && t >= f1 && t < f1 + c_vsl[k] * ht);
        hs_lo = hh < c_hsw[k];
        cl_lo = (hh >= c_hsw[k]) && (hh < c_hsw[k] + c_clw[k]);
        vact  = md[1] ? c_vap[k] : c_van[k];
        act   = (hh >= c_has[k]) && (hh < c_has[k] + c_haw[k]) &&
                (vv >= c_vas[k]) && (vv < c_vas[k] + vact);
        if (ph == 0)
            return (vs_lo ? 0 : 8) + (cl_lo ? 0 : 4) + (hs_lo ? 0 : 2) + ((vs_lo || hs_lo) ? 0 : 1);
        if (!act) return 0;
`ifdef N64_VGEN_COLORBARS_EN
        b = (hh - c_has[k]) / (c_haw[k] / 8);
        return (((b >> (3 - ph)) & 1) != 0) ? 127 : 0;
`else
        b = 0;
        return 63 + b;
`endif
    endfunction

    function automatic void model_edge(int k);
        if (RST) begin
            e_nvd[k] = 1;
            e_d[k]   = 0;
            m_ph[k]  = 0;
            m_t[k]   = 0;
            m_md[k]  = {pal_i, il_i};
        end else if (!en) begin
            e_nvd[k] = 1;
            e_d[k]   = 0;
        end else begin
            e_nvd[k] = (m_ph[k] != 0) ? 1 : 0;
            e_d[k]   = slot_data(k, m_ph[k], m_t[k], m_md[k]);
            m_ph[k]  = (m_ph[k] + 1) % 4;
            if (m_ph[k] == 0) begin
                m_t[k]++;
                if (m_t[k] == period(k, m_md[k])) begin
                    m_t[k]  = 0;
                    m_md[k] = {pal_i, il_i};
                end
            end
        end
        e_md[k] = m_md[k];
    endfunction

    function automatic void monitor();
        bit vs, hs;
        if (nvd_s != 1'b0) return;
        vs = d_s[3];
        hs = d_s[1];
        mon_s++;
        if (prev_vs && !vs) begin
            if (mon_seen) begin
                iv_q.push_back(mon_s);
                hc_q.push_back(mon_hc);
            end
            mon_seen = 1;
            mon_s    = 0;
            mon_hc   = 0;
        end else if (prev_hs && !hs) begin
            mon_hc++;
        end
        prev_vs = vs;
        prev_hs = hs;
    endfunction

    function automatic void mon_clear();
        mon_seen = 0;
        iv_q.delete();
        hc_q.delete();
    endfunction

    task automatic tick();
        @(posedge VCLK);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        check("nvd_s", int'(nvd_s), e_nvd[0]);
        check("d_s", int'(d_s), e_d[0]);
        check("md_s", int'(md_s), int'(e_md[0]));
        check("nvd_d", int'(nvd_d), e_nvd[1]);
        check("d_d", int'(d_d), e_d[1]);
        check("md_d", int'(md_d), int'(e_md[1]));
        monitor();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_vmode(input logic [1:0] want, input int budget, input string tag);
        int n;
        n = 0;
        while (md_s !== want && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(md_s), int'(want));
    endtask

    task automatic check_intervals(input string tag, input int iv_a, input int iv_b, input int hc);
        check({tag, "_count"}, (iv_q.size() >= 3) ? 1 : 0, 1);
        for (int i = 0; i < 3 && i < iv_q.size(); i++) begin
            check({tag, "_iv"}, iv_q[i], (i % 2 == 0) ? iv_a : iv_b);
            check({tag, "_hs"}, hc_q[i], hc);
        end
    endtask

    int ntsc_iv, pal_iv0, pal_iv1;

    initial begin
        ntsc_iv = c_vln[0] * c_htn[0];
        pal_iv0 = (c_vlp[0] - 1) * c_htp[0] + c_htp[0] / 2;
        pal_iv1 = (c_htp[0] - c_htp[0] / 2) + (c_vlp[0] - 1) * c_htp[0];

        // Reset, NTSC 240p
        run(3);
        check("rst_md", int'(md_s), 0);
        check("rst_nvd", int'(nvd_s), 1);
        RST = 1'b0;
        tick();
        check("first_nvd", int'(nvd_s), 0);
        check("first_nib", int'(d_s), 7'h04);
        check("first_nib_dflt", int'(d_d), 7'h04);
        run(3 * 4 * ntsc_iv + 50);
        check_intervals("ntsc240", ntsc_iv, ntsc_iv, c_vln[0] - 1);

        // PAL 480i with an enable gap inside the measured window
        pal_i = 1'b1;
        il_i  = 1'b1;
        wait_vmode(2'b11, 4 * ntsc_iv + 100, "to_pal480i");
        mon_clear();
        run(2000);
        en = 1'b0;
        run(500);
        check("hold_nvd", int'(nvd_s), 1);
        check("hold_d", int'(d_s), 0);
        en = 1'b1;
        run(4 * (pal_iv0 + pal_iv1) + 4 * pal_iv0);
        check_intervals("pal480i", pal_iv0, pal_iv1, c_vlp[0] - 1);

        // Switch to NTSC 240p while in field 1: deferred to the next field-0 start
        begin
            int n;
            n = 0;
            while (m_t[0] < c_vlp[0] * c_htp[0] + 40 && n < 8000) begin
                tick();
                n++;
            end
        end
        pal_i = 1'b0;
        il_i  = 1'b0;
        tick();
        check("vmode_hold", int'(md_s), 3);
        wait_vmode(2'b00, 8000, "to_ntsc240");
        mon_clear();
        tick();
        check("f0_nib", int'(d_s), 7'h04);
        run(3 * 4 * ntsc_iv + 50);
        check_intervals("ntsc_after", ntsc_iv, ntsc_iv, c_vln[0] - 1);

        // Random enable and mode requests against the model
        for (int i = 0; i < 8000; i++) begin
            if (i % 600 == 0) begin
                pal_i = 1'($urandom_range(1, 0));
                il_i  = 1'($urandom_range(1, 0));
            end
            en = ($urandom_range(15, 0) != 0);
            tick();
        end

        // Reset mid-line wins over en_i=0 and a pending mode request
        en = 1'b1;
        run(700 + int'($urandom_range(300, 0)));
        RST   = 1'b1;
        en    = 1'b0;
        pal_i = 1'b1;
        il_i  = 1'b0;
        tick();
        check("rstmid_nvd", int'(nvd_s), 1);
        check("rstmid_d", int'(d_s), 0);
        check("rstmid_md", int'(md_s), 2);
        RST = 1'b0;
        en  = 1'b1;
        tick();
        check("rstmid_nib", int'(d_s), 7'h04);
        check("rstmid_nvd0", int'(nvd_s), 0);
        run(200);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/n64_vgen.md
# n64_vgen

Synthetic N64 video source: generates the demultiplexed VI bus (nVDSYNC plus 7-bit data carrying sync nibble, R, G, B) with NTSC/PAL and 240p/480i field timing. The sync pattern is constructed so the video-info extraction stage in the PPU decodes `vdata_detected`, `palmode` and `n64_480i` exactly as selected. It serves as an in-FPGA loopback source for bring-up and as the stimulus driver for PPU benches.

## Interface
- `H_TOTAL_NTSC`, 773: pixel slots per line, NTSC
- `H_TOTAL_PAL`, 794: pixel slots per line, PAL
- `H_SYNC_W`, 57: nHSYNC low width, pixel slots
- `CLAMP_W`, 30: nCLAMP low width, starting at slot `H_SYNC_W`
- `H_ACT_START`, 108: first active pixel slot; active width fixed at 640
- `V_SYNC_LINES`, 3: nVSYNC low duration, lines
- `V_ACT_START`, 18: first active line of field; active height 240 NTSC / 288 PAL

Ports:
- `VCLK`  in  1  video clock
- `RST`  in  1  synchronous, active-high reset
- `en_i`  in  1  run enable
- `palmode_i`  in  1  requested mode: 1 = PAL, 0 = NTSC
- `n64_480i_i`  in  1  requested scan: 1 = 480i/576i, 0 = 240p/288p
- `nVDSYNC_o`  out  1  low on the sync-nibble cycle of each pixel slot
- `D_o`  out  7  VI data bus
- `vmode_o`  out  2  `{palmode, n64_480i}` currently in effect

## Operation
- Pixel slot = 4 VCLK cycles, phase counter 0..3. Phase 0: `nVDSYNC_o`=0, `D_o`={3'b000, nVSYNC, nCLAMP, nHSYNC, nCSYNC}. Phases 1/2/3: `nVDSYNC_o`=1, `D_o`=R/G/B.
- Horizontal counter `h` runs 0..H_TOTAL-1 (mode-selected), wraps, and increments line counter `v`.
- nHSYNC = 0 for h < H_SYNC_W. nCLAMP = 0 for H_SYNC_W ≤ h < H_SYNC_W+CLAMP_W. nCSYNC = nHSYNC & nVSYNC.
- Field lengths: 240p → every field is 263 lines (NTSC) or 313 lines (PAL); nVSYNC falls at h=0, v=0.
- 480i → field 0 is 263/313 lines; field 1 is 262/312 lines. Field-0 nVSYNC falls at h=0, v=0. Field-1 nVSYNC falls at h=H_TOTAL/2 (integer division) of the last line of field 0, and stays low for V_SYNC_LINES lines from that point.
- Result: exactly 262 (NTSC) or 312 (PAL) nHSYNC falling edges lie strictly between consecutive nVSYNC falling edges, in every mode.
  - `palmode` decodes correctly from count mod 4.
  - Field-0 vsync is coincident with an nHSYNC fall; field-1 vsync is not. So 480i toggles field parity and 240p does not.
- Mode latch: `palmode_i`/`n64_480i_i` are sampled into `vmode_o` only when wrapping into field 0, v=0, h=0. Mid-field changes are deferred. A switch to 240p taken while in field 1 completes field 1 first.
- Active region (h, v in range) outputs pixel colour; outside it R=G=B=0.
- `en_i`=0: all counters hold; `nVDSYNC_o`=1, `D_o`=0. Resuming continues from the held position.

## Timing
- All outputs registered; one VCLK from counter state to output.
- Reset values:
  - outputs: `nVDSYNC_o`=1, `D_o`=0, `vmode_o`={palmode_i, n64_480i_i} sampled at reset
  - counters: phase=0, h=0, v=0, field=0
- First cycle after RST deasserts (with en_i=1): phase-0 slot with nVSYNC=0, nHSYNC=0, nCSYNC=0, nCLAMP=1.
- RST mid-line takes priority over everything, including en_i and a pending mode latch.
- Field counter toggles only in 480i. In 240p it stays 0.

## Configuration
- `N64_VGEN_COLORBARS_EN` defined: active area shows 8 vertical bars, 80 pixels each. Bar index b=(h-H_ACT_START)/80. R=b[2]?7'h7F:0, G=b[1]?7'h7F:0, B=b[0]?7'h7F:0.
- Undefined: active area is flat grey, R=G=B=7'h3F, and no bar logic is synthesised.

## Test plan
- Reset, NTSC 240p, en=1 → one nVDSYNC low every 4 cycles; nVSYNC falls every 263×773 slots; 262 nHSYNC falls between vsyncs; extractor reports vinfo=3'b100 after two lines.
- PAL 480i → successive vsync intervals both equal 312.5 lines (248125 slots); extractor reports vinfo=3'b111.
- Toggle n64_480i_i 1→0 mid field 1 → vmode_o changes exactly at the next field-0 start; intervals then constant at 263×773 slots (NTSC).
- en_i=0 for 5000 cycles → D_o=0, nVDSYNC_o=1 throughout; extractor vdata_detected drops to 0; on re-enable, the sync position resumes unchanged.
- Colour bars enabled, NTSC line 18 → slot 108 R/G/B = 0/0/0; slot 668 = 7F/7F/7F; slot 107 = 0/0/0.
- RST pulse at h=400, v=100 → next cycle outputs the reset sync nibble with v=0, h=0.
